// File: rtl/rocket_array.sv
// Multi-channel rocket sprite generator: per-channel line counters, 16x16 mirrored ROM, combined sprite output.
// Optional: define ROCKET_ARRAY_WIN_DELAY_EN to delay the combined window/pixel by WIN_DELAY clocks.
module rocket_array #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned YW           = 8,
  parameter int unsigned LINES_ACTIVE = 246,
  parameter int unsigned HPOS_BASE    = 192,
  parameter int unsigned HPOS_STEP    = 112,
  parameter int unsigned WIN_DELAY    = 6
) (
  input  logic              i_clk_drv,
  input  logic              i_reset_n,
  input  logic              i_line_en,
  input  logic              i_pix_en,
  input  logic              i_vblank,
  input  logic              i_vreset,
  input  logic              i_bbound_en,
  input  logic [8:0]        i_hcount,
  input  logic [NUM_CH-1:0] i_up_n,
  input  logic [NUM_CH-1:0] i_down_n,
  input  logic [NUM_CH-1:0] i_crash_n,
  input  logic              i_game_on,
  input  logic              i_r_reset,
  output logic              o_sprite_n,
  output logic [NUM_CH-1:0] o_pix,
  output logic [NUM_CH-1:0] o_score,
  output logic [NUM_CH-1:0] o_sr
);

  localparam int unsigned Y_MAX   = (1 << YW) - 1;
  localparam int unsigned Y_TOP   = (1 << YW) - 16;
  localparam int unsigned Y_RELOAD = (1 << YW) - LINES_ACTIVE;

  function automatic logic [7:0] rom_row(input logic [3:0] row);
    logic [7:0] bits;
    bits = 8'h00;
    case (row)
      4'h0: bits = 8'h80;
      4'h1: bits = 8'h40;
      4'h2: bits = 8'h20;
      4'h3: bits = 8'h10;
      4'h4: bits = 8'h38;
      4'h5: bits = 8'h20;
      4'h6: bits = 8'h20;
      4'h7: bits = 8'h20;
      4'h8: bits = 8'h20;
      4'h9: bits = 8'h10;
      4'hA: bits = 8'h08;
      4'hB: bits = 8'h04;
      4'hC: bits = 8'h02;
      4'hD: bits = 8'hEF;
      4'hE: bits = 8'h28;
      4'hF: bits = 8'h38;
      default: bits = 8'h00;
    endcase
    return bits;
  endfunction

  logic              r_vblank_d;
  logic              w_vblank_fall;
  logic [NUM_CH-1:0] w_win;
  logic              w_win_any;
  logic              w_pix_any;
  logic              w_win_d;
  logic              w_pix_d;
  logic              r_sprite_n;

  assign w_vblank_fall = r_vblank_d & ~i_vblank;

  always_ff @(posedge i_clk_drv or negedge i_reset_n) begin
    if (!i_reset_n) r_vblank_d <= 1'b0;
    else            r_vblank_d <= i_vblank;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int unsigned H_START = HPOS_BASE + c * HPOS_STEP;

    logic [YW-1:0] r_y;
    logic          r_score;
    logic          r_bb;
    logic          w_top;
    logic          w_stop;
    logic          w_down;
    logic          w_up;
    logic [YW-1:0] w_reload;
    logic          w_in_range;
    logic [3:0]    w_x;
    logic [2:0]    w_m;
    logic [7:0]    w_rom;

    assign w_top    = (r_y >= YW'(Y_TOP));
    assign w_stop   = r_score | r_bb;
    // Down beats up; a stopped rocket ignores down.
    assign w_down   = ~i_down_n[c] & ~w_stop;
    assign w_up     = ~i_up_n[c] & ~w_down;
    assign w_reload = w_down ? YW'(Y_RELOAD - 1) :
                      w_up   ? YW'(Y_RELOAD + 1) : YW'(Y_RELOAD);

    assign o_sr[c]  = ~i_crash_n[c] | ~i_game_on;

    always_ff @(posedge i_clk_drv or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_y <= '0;
      end else if (o_sr[c] && i_r_reset) begin
        r_y <= '0;
      end else if (i_line_en && !i_vblank) begin
        r_y <= (r_y == YW'(Y_MAX)) ? w_reload : r_y + YW'(1);
      end
    end

    always_ff @(posedge i_clk_drv or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_score <= 1'b0;
        r_bb    <= 1'b0;
      end else begin
        if (w_vblank_fall) r_score <= w_top;
        if (i_bbound_en)   r_bb    <= w_top;
      end
    end

    assign w_in_range = (32'(i_hcount) >= 32'(H_START)) && (32'(i_hcount) < 32'(H_START + 16));
    assign w_x        = 4'(32'(i_hcount) - 32'(H_START));
    // Right half mirrors the left: 15-x equals ~x[2:0] for x in 8..15.
    assign w_m        = w_x[3] ? ~w_x[2:0] : w_x[2:0];
    assign w_rom      = rom_row(r_y[3:0]);
    assign w_win[c]   = w_top & i_crash_n[c] & ~i_vreset & w_in_range;
    assign o_pix[c]   = w_win[c] & w_rom[w_m];
    assign o_score[c] = r_score;
  end

  assign w_win_any = |w_win;
  assign w_pix_any = |o_pix;

`ifdef ROCKET_ARRAY_WIN_DELAY_EN
  logic [WIN_DELAY-1:0] r_win_sr;
  logic [WIN_DELAY-1:0] r_pix_sr;

  always_ff @(posedge i_clk_drv or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_win_sr <= '0;
      r_pix_sr <= '0;
    end else begin
      r_win_sr <= WIN_DELAY'({r_win_sr, w_win_any});
      r_pix_sr <= WIN_DELAY'({r_pix_sr, w_pix_any});
    end
  end

  assign w_win_d = r_win_sr[WIN_DELAY-1];
  assign w_pix_d = r_pix_sr[WIN_DELAY-1];
`else
  assign w_win_d = w_win_any;
  assign w_pix_d = w_pix_any;
`endif

  // Sprite output advances only on pixel-clock enables.
  always_ff @(posedge i_clk_drv or negedge i_reset_n) begin
    if (!i_reset_n)    r_sprite_n <= 1'b1;
    else if (i_pix_en) r_sprite_n <= w_win_d ? ~w_pix_d : 1'b1;
  end

  assign o_sprite_n = r_sprite_n;

endmodule

// File: tb/tb_rocket_array.sv
// Scoreboard bench for rocket_array: reset, restart, ROM row pattern, reload adjustments, async reset.
module tb_rocket_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line_en, pix_en, vblank, vreset, bbound_en;
  logic [8:0] hcount;
  logic [1:0] up_n, down_n, crash_n;
  logic       game_on, r_reset;
  logic       sprite_n;
  logic [1:0] pix, score, sr;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  rom_t[16] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h38, 8'h20, 8'h20, 8'h20,
                             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'hEF, 8'h28, 8'h38};

  always #5 clk = ~clk;

  rocket_array dut (
    .i_clk_drv  (clk),
    .i_reset_n  (rst_n),
    .i_line_en  (line_en),
    .i_pix_en   (pix_en),
    .i_vblank   (vblank),
    .i_vreset   (vreset),
    .i_bbound_en(bbound_en),
    .i_hcount   (hcount),
    .i_up_n     (up_n),
    .i_down_n   (down_n),
    .i_crash_n  (crash_n),
    .i_game_on  (game_on),
    .i_r_reset  (r_reset),
    .o_sprite_n (sprite_n),
    .o_pix      (pix),
    .o_score    (score),
    .o_sr       (sr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk(tag, obs, e);
  endtask

  function automatic logic exp_pix(input int row, input int x);
    logic [7:0] r;
    int m;
    r = rom_t[row];
    m = (x < 8) ? x : 15 - x;
    return r[m];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line();
    line_en = 1'b1;
    tick();
    line_en = 1'b0;
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) line();
  endtask

  task automatic vb_pulse();
    vblank = 1'b1;
    tick(); tick();
    vblank = 1'b0;
    tick(); tick();
  endtask

  task automatic bb_pulse();
    bbound_en = 1'b1;
    tick();
    bbound_en = 1'b0;
    tick();
  endtask

  // Hold hcount long enough to fill any window delay, then one pixel enable.
  task automatic pix_pulse();
    repeat (8) tick();
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
  endtask

  // Lines from just after a reload until channel 0's rocket first shows (row 0, column 7).
  task automatic measure(output int n);
    hcount = 9'd199;
    n = 0;
    while (n < 300) begin
      line();
      n++;
      #1;
      if (pix[0] === 1'b1) break;
    end
  endtask

  initial begin
    int n;
    logic e;
    rst_n = 1'b0; line_en = 0; pix_en = 0; vblank = 0; vreset = 0; bbound_en = 0;
    hcount = '0; up_n = 2'b11; down_n = 2'b11; crash_n = 2'b11; game_on = 1; r_reset = 0;
    repeat (3) tick();
    chk("rst_sprite_n", 32'(sprite_n), 32'd1);
    chk("rst_pix", 32'(pix), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_sr", 32'(sr), 32'd0);
    rst_n = 1'b1;
    tick();

    crash_n = 2'b01; #1;
    chk("sr_crash1", 32'(sr), 32'd2);
    game_on = 1'b0; #1;
    chk("sr_gameoff", 32'(sr), 32'd3);
    game_on = 1'b1; crash_n = 2'b11;

    // From Y=0, 253 lines reach 0xFD (row D) on both channels.
    lines(253);
    for (int x = 0; x < 16; x++) begin
      hcount = 9'(192 + x);
      #1;
      e = exp_pix(13, x);
      exp_q.push_back(32'(e));
      sb_pop("pix0_rowD", 32'(pix[0]));
      exp_q.push_back(32'(!e));
      pix_pulse();
      sb_pop("sprite_rowD", 32'(sprite_n));
    end
    hcount = 9'd304; #1;
    chk("pix1_rowD_x0", 32'(pix[1]), 32'd1);
    hcount = 9'd308; #1;
    chk("pix1_rowD_x4", 32'(pix[1]), 32'd0);

    crash_n = 2'b01; r_reset = 1'b1;
    tick();
    crash_n = 2'b11; r_reset = 1'b0;
    hcount = 9'd304; #1;
    chk("pix1_after_restart", 32'(pix[1]), 32'd0);
    chk("sr_released", 32'(sr), 32'd0);
    hcount = 9'd192; #1;
    chk("pix0_unaffected", 32'(pix[0]), 32'd1);

    vb_pulse();
    chk("score_vblank_fall", 32'(score), 32'd1);
    bb_pulse();

    // Stopped rocket: down ignored, reload 10.
    lines(2);
    down_n = 2'b10;
    exp_q.push_back(32'd230);
    line();
    down_n = 2'b11;
    measure(n);
    sb_pop("reload_down_stopped", 32'(n));

    // Up: reload 11; then clear score and back-boundary flags.
    lines(15);
    up_n = 2'b10;
    exp_q.push_back(32'd229);
    line();
    up_n = 2'b11;
    vb_pulse();
    bb_pulse();
    chk("score0_cleared", 32'(score[0]), 32'd0);
    measure(n);
    sb_pop("reload_up", 32'(n));

    // Up and down together, not stopped: down wins, reload 9.
    lines(15);
    up_n = 2'b10; down_n = 2'b10;
    exp_q.push_back(32'd231);
    line();
    up_n = 2'b11; down_n = 2'b11;
    measure(n);
    sb_pop("reload_up_down", 32'(n));

    // No input: back to reload 10.
    lines(15);
    exp_q.push_back(32'd230);
    line();
    measure(n);
    sb_pop("reload_idle", 32'(n));

    vb_pulse();
    chk("score0_top", 32'(score[0]), 32'd1);
    pix_pulse();
    chk("sprite_lit_row0", 32'(sprite_n), 32'd0);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_sprite_n", 32'(sprite_n), 32'd1);
    chk("async_rst_pix", 32'(pix), 32'd0);
    chk("async_rst_score", 32'(score), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rocket_array.md
ROCKET_ARRAY -- requirements
Module: rocket_array

Interface
REQ-001 Parameter NUM_CH, default 2, number of rocket channels (1..4).
REQ-002 Parameter YW, default 8, y-position counter width.
REQ-003 Parameter LINES_ACTIVE, default 246, active lines per frame.
REQ-004 Parameter HPOS_BASE, default 192; HPOS_STEP, default 112.
- Channel c occupies HCOUNT in [HPOS_BASE + c*HPOS_STEP, +16).
REQ-005 Parameter WIN_DELAY, default 6, window delay in CLK_DRV cycles.
REQ-006 CLK_DRV  in  1  single system clock; all state on its rising edge.
REQ-007 RESET_N  in  1  asynchronous, active-low reset.
REQ-008 LINE_EN  in  1  one-cycle strobe per horizontal line.
REQ-009 PIX_EN  in  1  pixel-clock enable.
REQ-010 VBLANK  in  1  vertical blank level.
REQ-011 VRESET  in  1  frame-reset line level.
REQ-012 BBOUND_EN  in  1  strobe on the back-boundary line.
REQ-013 HCOUNT  in  9  horizontal pixel count.
REQ-014 UP_N, DOWN_N, CRASH_N  in  NUM_CH each  per-channel active-low controls.
REQ-015 GAME_ON  in  1  game running.
REQ-016 R_RESET  in  1  rocket restart enable.
REQ-017 SPRITE_N  out  1  registered combined rocket pixel, active low.
REQ-018 PIX  out  NUM_CH  per-channel unregistered pixel.
REQ-019 SCORE  out  NUM_CH  per-channel score flag.
REQ-020 SR  out  NUM_CH  per-channel restart request.

Function
REQ-021 Each channel SHALL keep a YW-bit counter Y[c]. Y[c] increments on LINE_EN when VBLANK=0.
REQ-022 On LINE_EN with VBLANK=0 and Y[c] = all-ones, Y[c] SHALL reload instead of incrementing. The reload value is L = 2^YW - LINES_ACTIVE (10 at defaults), adjusted as follows:
- L+1 when UP_N[c]=0 and no down action.
- L-1 when DOWN_N[c]=0 and STOP[c]=0.
- Down wins when up and down are both active.
REQ-023 SR[c] SHALL equal (!CRASH_N[c] | !GAME_ON), combinational.
REQ-024 When SR[c] & R_RESET, Y[c] SHALL clear to 0 on the next clock edge, overriding count and reload.
REQ-025 TOP[c] SHALL mean Y[c] >= 2^YW-16. Row index is Y[c][3:0].
REQ-026 SCORE[c] SHALL register TOP[c] on the falling edge of VBLANK. BB[c] SHALL register TOP[c] on BBOUND_EN.
REQ-027 STOP[c] SHALL equal SCORE[c] | BB[c].
REQ-028 WIN[c] SHALL equal TOP[c] & CRASH_N[c] & !VRESET & HCOUNT within the channel's range. Column x = HCOUNT - start.
REQ-029 The mirrored column SHALL be m = x for x<8, else 15-x. PIX[c] SHALL be WIN[c] & ROM[row][m].
REQ-030 ROM rows 0..15, bit m set = pixel lit, in hex: 80,40,20,10,38,20,20,20,20,10,08,04,02,EF,28,38.
REQ-031 Combined window and pixel SHALL be the OR over channels.
REQ-032 On PIX_EN, SPRITE_N SHALL load ~pixel when the (delayed) window is 1, else 1. Latency is one PIX_EN.
REQ-033 Overlapping channel windows SHALL OR their pixels.

Reset
REQ-034 While RESET_N=0, the following SHALL be held:
- Y = 0, SCORE = 0, BB = 0.
- Delay pipeline = 0.
- SPRITE_N = 1.
- PIX = 0, because TOP is 0 while Y = 0.
REQ-035 Deassertion SHALL take effect from the first CLK_DRV edge after release. Reset mid-frame SHALL discard all position state.

Configuration
REQ-036 With ROCKET_ARRAY_WIN_DELAY_EN defined, the combined window and pixel SHALL pass through a WIN_DELAY-stage CLK_DRV shift register before REQ-032.
REQ-037 Without ROCKET_ARRAY_WIN_DELAY_EN, REQ-032 SHALL use the undelayed signals.

Verification
REQ-038 No inputs, 3 frames, 246 active lines each -> Y[0] at each frame start identical; rocket row identical every frame.
REQ-039 UP_N[0]=0 for 1 frame -> reload 11; rocket appears one line higher next frame.
REQ-040 DOWN_N[0]=0 with BB[0]=1 -> reload stays 10 (stop honoured).
- Both UP_N[0] and DOWN_N[0] low with STOP=0 -> reload 9.
REQ-041 CRASH_N[1]=0 with R_RESET=1 -> SR[1]=1, Y[1]=0 next clock, PIX[1]=0.
- Channel 0 unaffected.
REQ-042 Y[0]=0xFD, HCOUNT=192..207 -> PIX[0] pattern 1111011111101111 (row D).
- SPRITE_N shows the same pattern inverted, one PIX_EN late (+6 cycles with the macro).
REQ-043 RESET_N low mid-frame -> all outputs at reset values within 0 clocks (asynchronous).
